cabac_bit_fetcher: RTL and testbench
====================================

// Module: cabac_bit_fetcher
// PURPOSE
//  Byte-to-bit adapter between the binary stream reader and the arithmetic decoding engine.
//  - Upstream: pulls bytes from the stream reader through a request/ready handshake.
//  - Buffering: keeps a BUF_W-bit window, MSB-first.
//  - Downstream: serves 0..MAX_RD bits per read to the decoding engine (init/renorm/bypass).
// PARAMETERS
//  BUF_W      32   window width in bits; multiple of 8, >= MAX_RD+8
//  MAX_RD     16   max bits per read
//  FETCH_LAT  2    cycles from src_req pulse to sampling src_data/src_ready
//  REFILL_TH  24   issue a byte fetch when fill_level <= REFILL_TH (<= BUF_W-8)
// PORTS
//  clk         in   1            clock, rising edge
//  rst         in   1            asynchronous, active-high reset
//  src_req     out  1            one-cycle byte request pulse to the stream reader
//  src_data    in   9            [7:0] byte; [8]=1 marks end of stream (byte discarded)
//  src_ready   in   1            reader holds valid data; 0 at sample time = no more data
//  rd_req      in   1            read request from the decoding engine
//  rd_len      in   5            bits requested, 0..MAX_RD
//  rd_ready    out  1            read accepted this cycle when rd_req && rd_ready
//  rd_valid    out  1            one-cycle pulse, rd_bits valid
//  rd_bits     out  MAX_RD       result, right-aligned, zero-extended
//  fill_level  out  6            valid bits in the window (0..BUF_W)
//  eos         out  1            sticky: stream exhausted
//  underflow   out  1            sticky: a read was served short at eos
// BEHAVIOUR
//  Reset (async, immediate): src_req=0, rd_ready=0, rd_valid=0, rd_bits=0, fill_level=0,
//   eos=0, underflow=0, window=0, fetch FSM=IDLE.
//  Fetch FSM:
//   - IDLE -> REQ: when fill_level <= REFILL_TH and !eos.
//   - REQ (1 cycle, src_req=1) -> WAIT.
//   - WAIT: counts FETCH_LAT cycles after REQ; on the last cycle samples the inputs:
//     - src_ready=1 and src_data[8]=0: append src_data[7:0] directly below the valid bits;
//       fill += 8; -> IDLE.
//     - src_ready=0 or src_data[8]=1: eos=1; -> DONE.
//   - DONE: terminal until reset.
//   - At most one byte is outstanding.
//   - src_ready is sampled only at the WAIT sample point; the level is ignored at all other times.
//  Read port:
//   - rd_ready = (fill_level >= rd_len) || eos; combinational from registered state and rd_len.
//   - Accept (rd_req && rd_ready): next cycle rd_valid=1 and rd_bits = top rd_len window bits.
//     Window shifts left by rd_len; fill -= rd_len.
//   - Latency: 1 cycle. Back-to-back accepts allowed, one per cycle.
//   - rd_len=0: accepted, rd_bits=0, window unchanged, rd_valid still pulses.
//   - rd_len > MAX_RD is illegal; the RTL clamps it to MAX_RD.
//  Simultaneous append and read in one cycle:
//   - The read sees the pre-append window.
//   - The byte lands at position (fill_level - rd_len) after the shift.
//   - fill_next = fill - rd_len + 8.
//  Eos short read: when rd_len > fill_level at eos:
//   - Returns the remaining bits MSB-aligned within rd_len, zero-padded below.
//   - fill becomes 0 and underflow=1.
//  Full window: no fetch is issued while fill_level > REFILL_TH, so fill never exceeds BUF_W.
//  Reset mid-fetch: the FSM returns to IDLE and the outstanding byte is dropped.
//   The stream position inside the reader is not rewound.
// STRUCTURE
//  Shared package cabac_stream_pkg:
//   - BUF_W/MAX_RD defaults and the byte width (8).
//   - Fetch-state enum {IDLE, REQ, WAIT, DONE}.
//   - End-of-stream flag bit index (8).
//  Sub-module cabac_bit_window: window register + fill counter.
//   Combinational extract/shift/append; inputs are the append byte and the read length.
//  The top level holds the fetch FSM, latency counter and read handshake.
// TESTING
//  1 Reader model returns bytes 0xA5,0x3C,0xFF,0x00:
//    - after reset, fill_level reaches 32 with no read issued;
//    - exactly 4 src_req pulses, spaced >= FETCH_LAT+1 cycles.
//  2 Same stream, reads of len 4,4,8,1:
//    -> rd_bits 0xA, 0x5, 0x3C, 0x1, each one cycle after accept.
//  3 Read len 16 with fill 24 while a byte arrives in the same cycle:
//    -> rd_bits = top 16 pre-append bits; fill_level = 16.
//  4 Stream of 2 bytes 0x81,0x7E, then src_ready=0:
//    - eos=1;
//    - read len 16 -> 0x817E;
//    - read len 5 -> 0x00, underflow=1.
//  5 Assert rst while in WAIT:
//    - all outputs go to reset values immediately;
//    - src_ready pulse during reset has no effect;
//    - the first fetch after release starts from IDLE.
//  6 rd_len=0 with fill 0 and !eos -> rd_ready=1, rd_valid pulse, rd_bits=0, fill unchanged.

Source files
------------

// File: rtl/cabac_stream_pkg.sv
// rtl/cabac_stream_pkg.sv - shared constants, fetch-state enum and length clamp for the CABAC bit fetcher
package cabac_stream_pkg;

  localparam int BUF_W_DEF  = 32;
  localparam int MAX_RD_DEF = 16;
  localparam int BYTE_W     = 8;
  localparam int EOS_BIT    = 8;
  localparam int FILL_W     = 6;
  localparam int LEN_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } fetch_state_e;

  // Oversized read lengths are treated as the largest legal read.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len, input int max_rd);
    logic [LEN_W-1:0] res;
    res = len;
    if (int'(len) > max_rd) res = LEN_W'(max_rd);
    return res;
  endfunction

endpackage

// File: rtl/cabac_bit_window.sv
// rtl/cabac_bit_window.sv - MSB-first bit window with fill counter, extract/shift/append datapath
module cabac_bit_window
  import cabac_stream_pkg::*;
#(
  parameter int BUF_W  = BUF_W_DEF,
  parameter int MAX_RD = MAX_RD_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_en_i,
  input  logic [LEN_W-1:0]  rd_len_i,
  input  logic              app_en_i,
  input  logic [BYTE_W-1:0] app_byte_i,
  output logic [FILL_W-1:0] fill_o,
  output logic [MAX_RD-1:0] rd_bits_o,
  output logic              short_o
);

  localparam int SH_W = FILL_W + 1;

  // Valid bits occupy the top fill_q positions; everything below is kept zero,
  // so a short read at end of stream naturally returns zero padding.
  logic [BUF_W-1:0]  win_q, win_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [FILL_W-1:0] len_fill;
  logic [SH_W-1:0]   extract_sh;
  logic [BUF_W-1:0]  top_bits;
  logic [BUF_W-1:0]  app_word;

  assign len_fill   = FILL_W'(rd_len_i);
  assign extract_sh = SH_W'(BUF_W) - SH_W'(rd_len_i);
  assign top_bits   = win_q >> extract_sh;
  assign rd_bits_o  = top_bits[MAX_RD-1:0];
  assign short_o    = fill_q < len_fill;
  assign app_word   = {app_byte_i, {(BUF_W-BYTE_W){1'b0}}};
  assign fill_o     = fill_q;

  // Read consumes from the pre-append window; the byte lands directly below what remains.
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (rd_en_i) begin
      win_d  = win_q << rd_len_i;
      fill_d = short_o ? '0 : (fill_q - len_fill);
    end
    if (app_en_i) begin
      win_d  = win_d | (app_word >> fill_d);
      fill_d = fill_d + FILL_W'(BYTE_W);
    end
  end

  // Window and fill registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/cabac_bit_fetcher.sv
// rtl/cabac_bit_fetcher.sv - byte-to-bit adapter between stream reader and arithmetic decoder
module cabac_bit_fetcher
  import cabac_stream_pkg::*;
#(
  parameter int BUF_W     = BUF_W_DEF,
  parameter int MAX_RD    = MAX_RD_DEF,
  parameter int FETCH_LAT = 2,
  parameter int REFILL_TH = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              src_req_o,
  input  logic [8:0]        src_data_i,
  input  logic              src_ready_i,
  input  logic              rd_req_i,
  input  logic [4:0]        rd_len_i,
  output logic              rd_ready_o,
  output logic              rd_valid_o,
  output logic [MAX_RD-1:0] rd_bits_o,
  output logic [5:0]        fill_level_o,
  output logic              eos_o,
  output logic              underflow_o
);

  localparam int CNT_W = 4;

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              eos_q, eos_d;
  logic              underflow_q, underflow_d;
  logic              rd_valid_q, rd_valid_d;
  logic [MAX_RD-1:0] rd_bits_q, rd_bits_d;

  logic [LEN_W-1:0]  len_c;
  logic [FILL_W-1:0] fill;
  logic [MAX_RD-1:0] win_bits;
  logic              win_short;
  logic              accept;
  logic              sample_now;
  logic              byte_ok;
  logic              app_en;

  assign len_c      = clamp_len(rd_len_i, MAX_RD);
  assign rd_ready_o = !rst_i && ((fill >= FILL_W'(len_c)) || eos_q);
  assign accept     = rd_req_i && rd_ready_o;
  assign sample_now = (state_q == ST_WAIT) && (cnt_q == CNT_W'(FETCH_LAT));
  assign byte_ok    = src_ready_i && !src_data_i[EOS_BIT];
  assign app_en     = sample_now && byte_ok;

  cabac_bit_window #(
    .BUF_W  (BUF_W),
    .MAX_RD (MAX_RD)
  ) u_window (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_en_i    (accept),
    .rd_len_i   (len_c),
    .app_en_i   (app_en),
    .app_byte_i (src_data_i[BYTE_W-1:0]),
    .fill_o     (fill),
    .rd_bits_o  (win_bits),
    .short_o    (win_short)
  );

  // Fetch FSM: one outstanding byte; inputs only looked at on the final WAIT cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    eos_d     = eos_q;
    src_req_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fill <= FILL_W'(REFILL_TH) && !eos_q) state_d = ST_REQ;
      end
      ST_REQ: begin
        src_req_o = 1'b1;
        cnt_d     = CNT_W'(1);
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (sample_now) begin
          if (byte_ok) begin
            state_d = ST_IDLE;
          end else begin
            eos_d   = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read response: one-cycle valid pulse, bits held until the next accept.
  always_comb begin
    rd_valid_d  = accept;
    rd_bits_d   = accept ? win_bits : rd_bits_q;
    underflow_d = underflow_q | (accept && win_short);
  end

  // State and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      eos_q       <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_bits_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      eos_q       <= eos_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
      rd_bits_q   <= rd_bits_d;
    end
  end

  assign rd_valid_o   = rd_valid_q;
  assign rd_bits_o    = rd_bits_q;
  assign fill_level_o = fill;
  assign eos_o        = eos_q;
  assign underflow_o  = underflow_q;

endmodule

// File: tb/tb_cabac_bit_fetcher.sv
// tb/tb_cabac_bit_fetcher.sv - scoreboard bench for cabac_bit_fetcher
module tb_cabac_bit_fetcher;

  localparam int FETCH_LAT = 2;

  logic        clk;
  logic        rst;
  logic        src_req_o;
  logic [8:0]  src_data;
  logic        src_ready;
  logic        rd_req;
  logic [4:0]  rd_len;
  logic        rd_ready_o;
  logic        rd_valid_o;
  logic [15:0] rd_bits_o;
  logic [5:0]  fill_level_o;
  logic        eos_o;
  logic        underflow_o;

  cabac_bit_fetcher #(
    .BUF_W     (32),
    .MAX_RD    (16),
    .FETCH_LAT (FETCH_LAT),
    .REFILL_TH (24)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .src_req_o    (src_req_o),
    .src_data_i   (src_data),
    .src_ready_i  (src_ready),
    .rd_req_i     (rd_req),
    .rd_len_i     (rd_len),
    .rd_ready_o   (rd_ready_o),
    .rd_valid_o   (rd_valid_o),
    .rd_bits_o    (rd_bits_o),
    .fill_level_o (fill_level_o),
    .eos_o        (eos_o),
    .underflow_o  (underflow_o)
  );

  typedef struct packed {
    logic [15:0] bits;
    logic [31:0] at;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  exp_t        sb[$];
  logic [8:0]  stream[$];
  int          s_idx   = 0;
  int          req_cnt = 0;
  int          last_req = -1000;
  int          min_gap  = 1000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Stream reader model: presents the next byte when a request pulse is seen.
  initial begin
    forever begin
      @(negedge clk);
      if (src_req_o) begin
        req_cnt++;
        if (cyc - last_req < min_gap) min_gap = cyc - last_req;
        last_req = cyc;
        if (s_idx < stream.size()) begin
          src_data  = stream[s_idx];
          src_ready = 1'b1;
          s_idx++;
        end else begin
          src_data  = 9'h000;
          src_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: every rd_valid pulse is matched against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid_o) begin
        if (sb.size() == 0) begin
          check("spurious_rd_valid", 32'(rd_valid_o), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rd_bits", 32'(rd_bits_o), 32'(e.bits));
          check("rd_latency", 32'(cyc), e.at);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    rd_req    = 1'b0;
    rd_len    = 5'd0;
    src_ready = 1'b0;
    src_data  = 9'h000;
    repeat (2) @(negedge clk);
    req_cnt  = 0;
    last_req = -1000;
    min_gap  = 1000;
    s_idx    = 0;
    rst      = 1'b0;
  endtask

  // Issue one read at the current negedge; ends at the following negedge.
  task automatic rd(input logic [4:0] len, input logic [15:0] exp, input string name);
    exp_t e;
    rd_req = 1'b1;
    rd_len = len;
    #1;
    check({name, "_ready"}, 32'(rd_ready_o), 32'd1);
    e.bits = exp;
    e.at   = 32'(cyc + 1);
    sb.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
    rd_len = 5'd0;
  endtask

  task automatic wait_fill(input int lvl, input string name);
    int k;
    k = 0;
    while (int'(fill_level_o) < lvl && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({name, "_fill_reached"}, 32'(int'(fill_level_o) >= lvl), 32'd1);
  endtask

  task automatic wait_eos(input string name);
    int k;
    k = 0;
    while (!eos_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({name, "_eos"}, 32'(eos_o), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_src_req"},   32'(src_req_o),    32'd0);
    check({name, "_rd_ready"},  32'(rd_ready_o),   32'd0);
    check({name, "_rd_valid"},  32'(rd_valid_o),   32'd0);
    check({name, "_rd_bits"},   32'(rd_bits_o),    32'd0);
    check({name, "_fill"},      32'(fill_level_o), 32'd0);
    check({name, "_eos"},       32'(eos_o),        32'd0);
    check({name, "_underflow"}, 32'(underflow_o),  32'd0);
  endtask

  initial begin
    int n;
    int k;
    logic [8:0] exp_byte;
    rst       = 1'b0;
    rd_req    = 1'b0;
    rd_len    = 5'd0;
    src_ready = 1'b0;
    src_data  = 9'h000;
    stream    = '{9'h0A5, 9'h03C, 9'h0FF, 9'h000};
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // zero-length read on an empty, live stream
    rd(5'd0, 16'h0000, "len0");
    check("len0_fill", 32'(fill_level_o), 32'd0);

    // fill to 32 with no reads
    wait_fill(32, "t1");
    check("t1_req_cnt", 32'(req_cnt), 32'd4);
    check("t1_req_gap", 32'(min_gap >= FETCH_LAT + 1), 32'd1);
    repeat (10) @(negedge clk);
    check("t1_no_extra_req", 32'(req_cnt), 32'd4);
    check("t1_eos_low", 32'(eos_o), 32'd0);

    // back-to-back reads 4,4,8,1
    rd(5'd4, 16'h000A, "t2_r4a");
    rd(5'd4, 16'h0005, "t2_r4b");
    rd(5'd8, 16'h003C, "t2_r8");
    rd(5'd1, 16'h0001, "t2_r1");
    wait_eos("t2");
    check("t2_fill", 32'(fill_level_o), 32'd15);
    rd(5'd15, 16'h7F00, "t2_r15");
    check("t2_fill_after", 32'(fill_level_o), 32'd0);
    check("t2_underflow", 32'(underflow_o), 32'd0);

    // read 16 in the same cycle the fourth byte lands
    stream = '{9'h012, 9'h034, 9'h056, 9'h078, 9'h09A, 9'h0BC, 9'h0DE, 9'h0F0};
    do_reset();
    n = 0;
    k = 0;
    while (n < 4 && k < 200) begin
      @(negedge clk);
      if (src_req_o) n++;
      k++;
    end
    check("t3_req_seen", 32'(n), 32'd4);
    repeat (FETCH_LAT) @(negedge clk);
    check("t3_pre_fill", 32'(fill_level_o), 32'd24);
    rd(5'd16, 16'h1234, "t3_r16");
    check("t3_post_fill", 32'(fill_level_o), 32'd16);
    rd(5'd16, 16'h5678, "t3_r16b");

    // reset while a fetch is in WAIT
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!src_req_o && k < 200);
    check("t5_req_seen", 32'(src_req_o), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs("t5_rst");
    exp_byte  = stream[s_idx];
    src_ready = 1'b1;
    src_data  = 9'h0EE;
    repeat (3) @(negedge clk);
    check("t5_fill_in_rst", 32'(fill_level_o), 32'd0);
    src_ready = 1'b0;
    src_data  = 9'h000;
    rst       = 1'b0;
    @(negedge clk);
    check("t5_first_req", 32'(src_req_o), 32'd1);
    wait_fill(8, "t5");
    rd(5'd8, 16'(exp_byte[7:0]), "t5_r8");

    // two bytes then src_ready low
    stream = '{9'h081, 9'h07E};
    do_reset();
    wait_eos("t4");
    check("t4_fill", 32'(fill_level_o), 32'd16);
    check("t4_underflow_pre", 32'(underflow_o), 32'd0);
    rd(5'd16, 16'h817E, "t4_r16");
    rd(5'd5, 16'h0000, "t4_r5");
    check("t4_underflow", 32'(underflow_o), 32'd1);
    check("t4_fill_after", 32'(fill_level_o), 32'd0);
    check("t4_eos_sticky", 32'(eos_o), 32'd1);
    check("t4_req_cnt", 32'(req_cnt), 32'd3);
    repeat (6) @(negedge clk);
    check("t4_no_req_done", 32'(req_cnt), 32'd3);

    // end-of-stream flag byte, then an oversized read clamped to 16
    stream = '{9'h05A, 9'h1FF};
    do_reset();
    wait_eos("t4b");
    check("t4b_fill", 32'(fill_level_o), 32'd8);
    rd(5'd20, 16'h5A00, "t4b_clamp");
    check("t4b_underflow", 32'(underflow_o), 32'd1);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
